// File: rtl/answer_display_sequencer.sv
// Pages a latched multi-byte answer onto two seven-segment digits, one byte per page,
// highest non-zero byte first, followed by an end marker, looping until cleared.
module answer_display_sequencer #(
    parameter int unsigned ANSWER_WIDTH = 64,
    parameter int unsigned PAGE_CYCLES  = 25000000,
    parameter int unsigned GAP_CYCLES   = 2500000,
    localparam int unsigned NB = ANSWER_WIDTH / 8,
    localparam int unsigned PW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    answer_valid,
    input  logic [ANSWER_WIDTH-1:0] answer,
    input  logic                    clear,
    output logic [6:0]              ss1_A_G,
    output logic [6:0]              ss2_A_G,
    output logic [PW-1:0]           page,
    output logic                    busy
);

    localparam int unsigned MAXC = (PAGE_CYCLES > GAP_CYCLES) ? PAGE_CYCLES : GAP_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] PAGE_LOAD = CW'(PAGE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_END   = 7'b0110110;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHOW    = 3'd1,
        ST_GAP     = 3'd2,
        ST_END     = 3'd3,
        ST_END_GAP = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           page_q, page_d;
    logic [PW-1:0]           top_q, top_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ANSWER_WIDTH-1:0] ans_q, ans_d;
    logic [6:0]              ss1_q, ss1_d;
    logic [6:0]              ss2_q, ss2_d;
    logic                    busy_q, busy_d;
    logic [7:0]              cur_byte;

    // Index of the highest non-zero byte; zero when the whole answer is zero.
    function automatic logic [PW-1:0] top_byte(input logic [ANSWER_WIDTH-1:0] v);
        top_byte = '0;
        for (int i = 0; i < int'(NB); i++) begin
            if (v[i*8 +: 8] != 8'd0) top_byte = PW'(i);
        end
    endfunction

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'b0000001;
            4'h1: hex_glyph = 7'b1001111;
            4'h2: hex_glyph = 7'b0010010;
            4'h3: hex_glyph = 7'b0000110;
            4'h4: hex_glyph = 7'b1001100;
            4'h5: hex_glyph = 7'b0100100;
            4'h6: hex_glyph = 7'b0100000;
            4'h7: hex_glyph = 7'b0001111;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0000100;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b1100000;
            4'hC: hex_glyph = 7'b0110001;
            4'hD: hex_glyph = 7'b1000010;
            4'hE: hex_glyph = 7'b0110000;
            default: hex_glyph = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            page_q  <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            ans_q   <= '0;
            ss1_q   <= SEG_DASH;
            ss2_q   <= SEG_DASH;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ans_q   <= ans_d;
            ss1_q   <= ss1_d;
            ss2_q   <= ss2_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: clear beats a new answer, and a new answer restarts from any state.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ans_d   = ans_q;
        if (clear) begin
            state_d = ST_IDLE;
            page_d  = '0;
            cnt_d   = '0;
        end else if (answer_valid) begin
            ans_d   = answer;
            top_d   = top_byte(answer);
            page_d  = top_byte(answer);
            cnt_d   = PAGE_LOAD;
            state_d = ST_SHOW;
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        cnt_d = PAGE_LOAD;
                        if (page_q != '0) begin
                            page_d  = page_q - PW'(1);
                            state_d = ST_SHOW;
                        end else begin
                            state_d = ST_END;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_END: begin
                    if (cnt_q == '0) begin
                        state_d = ST_END_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_END_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        page_d  = top_q;
                        cnt_d   = PAGE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        cur_byte = 8'd0;
        for (int i = 0; i < int'(NB); i++) begin
            if (page_q == PW'(i)) cur_byte = ans_q[i*8 +: 8];
        end
    end

    // Segments follow the current state, so they trail the state register by one cycle.
    always_comb begin
        ss1_d  = SEG_DASH;
        ss2_d  = SEG_DASH;
        busy_d = (state_d != ST_IDLE);
        case (state_q)
            ST_SHOW: begin
                ss1_d = hex_glyph(cur_byte[7:4]);
                ss2_d = hex_glyph(cur_byte[3:0]);
            end
            ST_GAP, ST_END_GAP: begin
                ss1_d = SEG_BLANK;
                ss2_d = SEG_BLANK;
            end
            ST_END: begin
                ss1_d = SEG_END;
                ss2_d = SEG_END;
            end
            default: begin
                ss1_d = SEG_DASH;
                ss2_d = SEG_DASH;
            end
        endcase
    end

    assign ss1_A_G = ss1_q;
    assign ss2_A_G = ss2_q;
    assign page    = page_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_answer_display_sequencer.sv
// Scoreboard bench for answer_display_sequencer with short page/gap times.
module tb_answer_display_sequencer;
    localparam int W = 20;
    localparam int K_SHOW  = 0;
    localparam int K_BLANK = 1;
    localparam int K_END   = 2;
    localparam logic [6:0] DASH = 7'b1111110;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        answer_valid = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] answer = '0;
    logic [6:0]  ss1_A_G, ss2_A_G;
    logic [2:0]  page;
    logic        busy;
    bit          clk_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    int           kind_a[256];
    logic [2:0]   pg_a[256];
    int           tl_n;

    answer_display_sequencer #(
        .ANSWER_WIDTH(64),
        .PAGE_CYCLES(4),
        .GAP_CYCLES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .answer_valid(answer_valid),
        .answer(answer),
        .clear(clear),
        .ss1_A_G(ss1_A_G),
        .ss2_A_G(ss2_A_G),
        .page(page),
        .busy(busy)
    );

    always begin
        #5;
        if (clk_en) clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b0000001;  4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;  4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;  4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;  4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;  4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;  4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;  4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;  default: font = 7'b0111000;
        endcase
    endfunction

    function automatic logic [13:0] segs_for(input logic [63:0] val, input int kind, input logic [2:0] p);
        logic [7:0] b;
        b = val[int'(p)*8 +: 8];
        if (kind == K_SHOW) segs_for = {font(b[7:4]), font(b[3:0])};
        else if (kind == K_END) segs_for = {7'b0110110, 7'b0110110};
        else segs_for = {7'b1111111, 7'b1111111};
    endfunction

    task automatic add_ent(input int kind, input logic [2:0] p);
        if (tl_n < 256) begin
            kind_a[tl_n] = kind;
            pg_a[tl_n]   = p;
            tl_n++;
        end
    endtask

    // Entry k is the state after the k-th edge from the one sampling answer_valid.
    task automatic push_seq(input logic [63:0] val, input int n_in);
        int top;
        int n;
        logic [13:0] s;
        n = (n_in > 255) ? 255 : n_in;
        top = 0;
        for (int b = 0; b < 8; b++) if (val[b*8 +: 8] != 8'd0) top = b;
        tl_n = 1;
        while (tl_n <= n) begin
            for (int p = top; p >= 0; p--) begin
                repeat (4) add_ent(K_SHOW, p[2:0]);
                repeat (2) add_ent(K_BLANK, p[2:0]);
            end
            repeat (4) add_ent(K_END, 3'd0);
            repeat (2) add_ent(K_BLANK, 3'd0);
        end
        for (int k = 1; k <= n; k++) begin
            s = (k >= 2) ? segs_for(val, kind_a[k-1], pg_a[k-1]) : 14'd0;
            exp_q.push_back({(k >= 2), 1'b1, s, pg_a[k], 1'b1});
        end
    endtask

    task automatic push_idle(input int n, input bit first_ss, input bit chk_pg);
        for (int k = 0; k < n; k++)
            exp_q.push_back({(k > 0) || first_ss, chk_pg, DASH, DASH, 3'd0, 1'b0});
    endtask

    task automatic step();
        logic [W-1:0] e;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (exp_q.size() == 0) begin
            check($sformatf("queue_underrun@%0d", cyc), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            if (e[19]) begin
                check($sformatf("ss1@%0d", cyc), 32'(ss1_A_G), 32'(e[17:11]));
                check($sformatf("ss2@%0d", cyc), 32'(ss2_A_G), 32'(e[10:4]));
            end
            if (e[18]) check($sformatf("page@%0d", cyc), 32'(page), 32'(e[3:1]));
            check($sformatf("busy@%0d", cyc), 32'(busy), 32'(e[0]));
        end
    endtask

    task automatic start_answer(input logic [63:0] val, input int n);
        answer = val;
        answer_valid = 1'b1;
        push_seq(val, n);
        step();
        answer_valid = 1'b0;
        repeat (n - 1) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Asynchronous reset with the clock stopped.
        #3 reset = 1'b0;
        #2;
        check("rst_ss1", 32'(ss1_A_G), 32'(DASH));
        check("rst_ss2", 32'(ss2_A_G), 32'(DASH));
        check("rst_page", 32'(page), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        clk_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        push_idle(3, 1'b1, 1'b1);
        repeat (3) step();

        // Two pages, two full loops.
        start_answer(64'h12AB, 38);
        // Zero answer: one page "00".
        start_answer(64'h0, 26);
        // Eight pages with zero bytes in the middle.
        start_answer(64'hFF00_0000_0000_0001, 56);
        // Restart while in GAP.
        start_answer(64'h12AB, 5);
        start_answer(64'h5, 14);
        // clear wins over a simultaneous valid during SHOW.
        start_answer(64'h12AB, 2);
        clear = 1'b1;
        answer_valid = 1'b1;
        answer = 64'h77;
        push_idle(4, 1'b0, 1'b0);
        step();
        clear = 1'b0;
        answer_valid = 1'b0;
        repeat (3) step();
        start_answer(64'h3C, 14);
        // A random single-byte answer.
        start_answer(64'($urandom_range(1, 255)), 14);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
